// File: rtl/axi_ram_responder.sv
// axi_ram_responder
// -----------------------------------------------------------------------------
// AXI4 slave endpoint backed by an on-chip word array. It accepts INCR, FIXED
// and WRAP bursts, narrow transfers and byte strobes. The write path (AW/W/B)
// and the read path (AR/R) are independent state machines. They share only the
// memory array, which has one write port and one read port.
//
// Handshake rule on every channel: a transfer happens on the rising edge where
// valid && ready. A source never withdraws valid or changes its payload while
// valid && !ready. Every ready/valid output here is a pure function of state
// registers, so no output depends combinationally on an input.
//
// Ports
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   s_axi_aw*                  write address channel (id, addr, len, size, burst)
//   s_axi_w*                   write data channel (data, strb, last is ignored)
//   s_axi_b*                   write response channel (bid = captured awid)
//   s_axi_ar*                  read address channel
//   s_axi_r*                   read data channel (rdata registered from RAM)
//
// The write and read state registers (w_state, r_state) are plain enums.
// Checkers can bind to them directly.
// -----------------------------------------------------------------------------
module axi_ram_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int WORD_WIDTH = ADDR_WIDTH - ADDR_LSB;
    localparam int DEPTH      = 2 ** WORD_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [2:0]            MAX_SIZE = 3'(ADDR_LSB);
    localparam logic [1:0]            BURST_FIXED = 2'd0;
    localparam logic [1:0]            BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // A beat wider than the bus is treated as a full-width beat.
    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        clamp_size = (size > MAX_SIZE) ? MAX_SIZE : size;
    endfunction

    // Address of the following beat. The step is taken from the address
    // aligned to the beat size, so an unaligned start lands on an aligned
    // second beat. WRAP keeps the step inside the (len+1)<<size window. A WRAP
    // whose length is not 2, 4, 8 or 16 beats steps as INCR.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [7:0]            len,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] wrap_mask;
        step      = ADDR_ONE << size;
        incr      = (addr & ~(step - ADDR_ONE)) + step;
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_ONE) << size) - ADDR_ONE;
        next_addr = incr;
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else if (burst == BURST_WRAP &&
                     (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
        end
    endfunction

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    w_state_t              w_state, w_state_next;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic [7:0]            w_cnt;
    logic                  aw_hs, w_hs;
    logic [WORD_WIDTH-1:0] w_word;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign w_word = w_addr[ADDR_WIDTH-1:ADDR_LSB];

    always_comb begin
        w_state_next  = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) w_state_next = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                // The burst length comes from awlen alone; wlast is not used.
                if (s_axi_wvalid && w_cnt == 8'd0) w_state_next = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            s_axi_bid <= '0;
            w_addr    <= '0;
            w_len     <= '0;
            w_size    <= '0;
            w_burst   <= '0;
            w_cnt     <= '0;
        end else begin
            w_state <= w_state_next;
            if (aw_hs) begin
                s_axi_bid <= s_axi_awid;
                w_addr    <= s_axi_awaddr;
                w_len     <= s_axi_awlen;
                w_size    <= clamp_size(s_axi_awsize);
                w_burst   <= s_axi_awburst;
                w_cnt     <= s_axi_awlen;
            end
            if (w_hs) begin
                w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
                w_cnt  <= w_cnt - 8'd1;
            end
        end
    end

    // A beat presented in a reset cycle is dropped. Earlier beats stay.
    always_ff @(posedge clk) begin
        if (!rst && w_hs) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) mem[w_word][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    assign s_axi_bresp = 2'b00;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    r_state_t              r_state, r_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_next;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_cnt;
    logic                  ar_hs, r_hs;

    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign r_hs   = s_axi_rvalid && s_axi_rready;
    assign r_next = next_addr(r_addr, r_size, r_len, r_burst);

    always_comb begin
        r_state_next  = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) r_state_next = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready && s_axi_rlast) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // The first word is fetched on the AR handshake. Each accepted non-last
    // beat fetches the next word in the same cycle, so a master holding
    // rready high sees one beat per cycle. A write to the same word in the
    // same cycle lands after the read sample, so the read returns the old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= R_IDLE;
            s_axi_rid   <= '0;
            s_axi_rdata <= '0;
            s_axi_rlast <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_cnt       <= '0;
        end else begin
            r_state <= r_state_next;
            if (ar_hs) begin
                s_axi_rid   <= s_axi_arid;
                s_axi_rdata <= mem[s_axi_araddr[ADDR_WIDTH-1:ADDR_LSB]];
                s_axi_rlast <= (s_axi_arlen == 8'd0);
                r_addr      <= s_axi_araddr;
                r_len       <= s_axi_arlen;
                r_size      <= clamp_size(s_axi_arsize);
                r_burst     <= s_axi_arburst;
                r_cnt       <= s_axi_arlen;
            end else if (r_hs) begin
                if (s_axi_rlast) begin
                    s_axi_rlast <= 1'b0;
                end else begin
                    s_axi_rdata <= mem[r_next[ADDR_WIDTH-1:ADDR_LSB]];
                    s_axi_rlast <= (r_cnt == 8'd1);
                    r_addr      <= r_next;
                    r_cnt       <= r_cnt - 8'd1;
                end
            end
        end
    end

    assign s_axi_rresp = 2'b00;

    logic unused_wlast;
    assign unused_wlast = s_axi_wlast;

endmodule

// File: tb/tb_axi_ram_responder.sv
// Testbench for axi_ram_responder (32-bit data, 16-bit address, 8-bit id).
// Inputs are driven and outputs sampled on the falling clock edge. Every
// driver task starts and ends on a falling edge.
module tb_axi_ram_responder;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int IW = 8;
    localparam int SW = DW / 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [IW-1:0] awid, bid, arid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;

    axi_ram_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] wd[16];
    logic [SW-1:0] ws[16];
    logic [DW-1:0] rd[16];
    logic [7:0]    mref[65536];

    typedef struct {
        logic [15:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [0:7][15:0]  exp_a;   // word address returned by each beat
    } rvec_t;
    rvec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual=timeout expected=handshake", name);
    endtask

    // ---------------- reference model ----------------
    // Byte address of beat i, derived directly from the burst rules.
    function automatic logic [15:0] beat_addr(input logic [15:0] start, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst,
                                              input int i);
        int nb, st, al, win, lo;
        nb = 1 << ((size > 3'd2) ? 2 : int'(size));
        st = int'(start);
        al = (st / nb) * nb;
        if (i == 0 || burst == 2'd0) return start;
        if (burst == 2'd2 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            win = nb * (int'(len) + 1);
            lo  = (st / win) * win;
            return 16'(lo + ((al - lo + i * nb) % win));
        end
        return 16'(al + i * nb);
    endfunction

    function automatic logic [31:0] model_word(input logic [15:0] a);
        int base;
        base = int'(a) & ~3;
        return {mref[base+3], mref[base+2], mref[base+1], mref[base]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic axi_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int gap, input int bdelay);
        int t, base;
        logic [15:0] a;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge clk); t++; end
        if (!awready) timeout_fail("aw_handshake");
        @(negedge clk);
        awvalid = 1'b0;
        check("awready_busy", awready, 0);
        for (int i = 0; i <= int'(len); i++) begin
            if (gap > 0) repeat ($urandom_range(gap, 0)) @(negedge clk);
            wdata = wd[i]; wstrb = ws[i]; wlast = (i == int'(len)); wvalid = 1'b1;
            t = 0;
            while (!wready && t < 50) begin @(negedge clk); t++; end
            if (!wready) timeout_fail("w_handshake");
            @(negedge clk);
            wvalid = 1'b0; wlast = 1'b0;
        end
        check("bvalid_after_last", bvalid, 1);
        check("bid", bid, id);
        check("bresp", bresp, 0);
        repeat (bdelay) begin
            @(negedge clk);
            check("bvalid_hold", bvalid, 1);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_clear", bvalid, 0);
        check("awready_after_b", awready, 1);
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, size, len, burst, i);
            base = int'(a) & ~3;
            for (int b = 0; b < SW; b++)
                if (ws[i][b]) mref[base+b] = wd[i][b*8 +: 8];
        end
    endtask

    // stall < 0: random 0..2 idle cycles before each beat; otherwise fixed.
    task automatic axi_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int stall, input bit use_sb);
        int t, ns;
        logic [31:0] held;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        if (!arready) timeout_fail("ar_handshake");
        @(negedge clk);
        arvalid = 1'b0;
        check("rvalid_after_ar", rvalid, 1);
        for (int i = 0; i <= int'(len); i++) begin
            ns = (stall < 0) ? int'($urandom_range(2, 0)) : stall;
            held = rdata;
            repeat (ns) begin
                @(negedge clk);
                check("rvalid_stall", rvalid, 1);
                check("rdata_stall", rdata, held);
            end
            if (!rvalid) timeout_fail("r_beat");
            rd[i] = rdata;
            check("rid", rid, id);
            check("rresp", rresp, 0);
            check("rlast", rlast, (i == int'(len)));
            if (use_sb) begin
                if (exp_q.size() == 0) timeout_fail("scoreboard_empty");
                else check("rdata", rdata, exp_q.pop_front());
            end
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
        check("rvalid_end", rvalid, 0);
        check("arready_end", arready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [15:0] sa;
        logic [7:0]  ln;
        logic [2:0]  sz;
        logic [1:0]  bt;

        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", awready, 1);
        check("rst_arready", arready, 1);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_bid", bid, 0);
        check("rst_rid", rid, 0);
        check("rst_rdata", rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Preload 0x000..0x0FF: each word holds 0xA500_0000 | its byte address.
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 16; i++) begin
                wd[i] = 32'hA500_0000 | 32'(blk * 64 + i * 4);
                ws[i] = 4'hF;
            end
            axi_write(8'h01, 16'(blk * 64), 8'd15, 3'd2, 2'd1, 0, 0);
        end

        // Address-generation table: start, len, size, burst -> word per beat
        tbl[0] = '{16'h0020, 8'd3, 3'd2, 2'd1, {16'h20, 16'h24, 16'h28, 16'h2C, 16'h0, 16'h0, 16'h0, 16'h0}};
        tbl[1] = '{16'h0018, 8'd3, 3'd2, 2'd2, {16'h18, 16'h1C, 16'h10, 16'h14, 16'h0, 16'h0, 16'h0, 16'h0}};
        tbl[2] = '{16'h0044, 8'd2, 3'd2, 2'd0, {16'h44, 16'h44, 16'h44, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};
        tbl[3] = '{16'h0034, 8'd1, 3'd2, 2'd2, {16'h34, 16'h30, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};
        tbl[4] = '{16'h0038, 8'd2, 3'd2, 2'd2, {16'h38, 16'h3C, 16'h40, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};
        tbl[5] = '{16'h0031, 8'd3, 3'd0, 2'd1, {16'h30, 16'h30, 16'h30, 16'h34, 16'h0, 16'h0, 16'h0, 16'h0}};
        tbl[6] = '{16'h0008, 8'd2, 3'd3, 2'd1, {16'h08, 16'h0C, 16'h10, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};
        tbl[7] = '{16'h004A, 8'd3, 3'd1, 2'd2, {16'h48, 16'h4C, 16'h4C, 16'h48, 16'h0, 16'h0, 16'h0, 16'h0}};
        tbl[8] = '{16'h0053, 8'd2, 3'd2, 2'd1, {16'h50, 16'h54, 16'h58, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};
        tbl[9] = '{16'h007C, 8'd7, 3'd2, 2'd2, {16'h7C, 16'h60, 16'h64, 16'h68, 16'h6C, 16'h70, 16'h74, 16'h78}};
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i <= int'(tbl[k].len); i++)
                exp_q.push_back(32'hA500_0000 | {16'h0, tbl[k].exp_a[i]});
            axi_read(8'(k + 16), tbl[k].addr, tbl[k].len, tbl[k].size, tbl[k].burst, 0, 1'b1);
        end

        // INCR write/read 0x10, four beats
        wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; wd[2] = 32'h3333_3333; wd[3] = 32'h4444_4444;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        axi_write(8'h05, 16'h0010, 8'd3, 3'd2, 2'd1, 0, 0);
        for (int i = 0; i < 4; i++) exp_q.push_back(wd[i]);
        axi_read(8'h09, 16'h0010, 8'd3, 3'd2, 2'd1, 0, 1'b1);

        // Byte strobes
        wd[0] = 32'h0; ws[0] = 4'hF;
        axi_write(8'h02, 16'h0040, 8'd0, 3'd2, 2'd1, 0, 0);
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
        axi_write(8'h03, 16'h0040, 8'd0, 3'd2, 2'd1, 0, 2);
        exp_q.push_back(32'h00BB_00DD);
        axi_read(8'h04, 16'h0040, 8'd0, 3'd2, 2'd1, 0, 1'b1);

        // WRAP read over words 0..3
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
        axi_write(8'h06, 16'h0010, 8'd3, 3'd2, 2'd1, 0, 0);
        exp_q.push_back(32'd2); exp_q.push_back(32'd3); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        axi_read(8'h07, 16'h0018, 8'd3, 3'd2, 2'd2, 0, 1'b1);

        // FIXED write keeps the last beat; read stalled for 3 cycles
        wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3;
        axi_write(8'h08, 16'h0020, 8'd2, 3'd2, 2'd0, 0, 0);
        exp_q.push_back(32'd3);
        axi_read(8'h0A, 16'h0020, 8'd0, 3'd2, 2'd1, 3, 1'b1);

        // Narrow INCR at 0x31: byte lanes 1, 2, 3 of one word
        wd[0] = 32'h0; ws[0] = 4'hF;
        axi_write(8'h0B, 16'h0030, 8'd0, 3'd2, 2'd1, 0, 0);
        wd[0] = 32'h0000_AA00; ws[0] = 4'b0010;
        wd[1] = 32'h00BB_0000; ws[1] = 4'b0100;
        wd[2] = 32'hCC00_0000; ws[2] = 4'b1000;
        axi_write(8'h0C, 16'h0031, 8'd2, 3'd0, 2'd1, 0, 0);
        exp_q.push_back(32'hCCBB_AA00);
        axi_read(8'h0D, 16'h0030, 8'd0, 3'd2, 2'd1, 0, 1'b1);

        // Reset during beat 2 of a 4-beat write to 0x80
        awid = 8'h0E; awaddr = 16'h0080; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("rstmid_wready", wready, 1);
        wdata = 32'hDEAD_0001; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wdata = 32'hDEAD_0002; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; wvalid = 1'b0;
        check("rstmid_wready_low", wready, 0);
        check("rstmid_bvalid", bvalid, 0);
        check("rstmid_awready", awready, 1);
        axi_read(8'h0F, 16'h0080, 8'd3, 3'd2, 2'd1, 0, 1'b0);
        check("rstmid_beat1", rd[0], 32'hDEAD_0001);
        check("rstmid_beat3", rd[2], 32'hA500_0088);
        check("rstmid_beat4", rd[3], 32'hA500_008C);

        // Randomized traffic in 0x200..0x3FF against the byte model
        for (int blk = 0; blk < 8; blk++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            axi_write(8'h20, 16'(16'h0200 + blk * 64), 8'd15, 3'd2, 2'd1, 0, 0);
        end
        for (int n = 0; n < 60; n++) begin
            sa = 16'(16'h0200 + $urandom_range(16'h017F, 0));
            ln = 8'($urandom_range(15, 0));
            sz = 3'($urandom_range(3, 0));
            bt = 2'($urandom_range(2, 0));
            if ($urandom_range(1, 0) == 1) begin
                for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(15, 0)); end
                axi_write(8'($urandom), sa, ln, sz, bt, 2, int'($urandom_range(2, 0)));
            end else begin
                for (int i = 0; i <= int'(ln); i++)
                    exp_q.push_back(model_word(beat_addr(sa, sz, ln, bt, i)));
                axi_read(8'($urandom), sa, ln, sz, bt, -1, 1'b1);
            end
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
